// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared widths, arbitration-mode encodings and the writeback request record
// for the register-file write-port arbiter.
package regfile_pkg;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback-requester, register-file write-port and hazard signals of the
// write arbiter; master = requester/regfile side, slave = arbiter.
interface regfile_wr_arbiter_if;
  import regfile_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              rf_load;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              haz_a;
  logic              haz_b;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output rd_addr_a, rd_addr_b,
    input  req0_ready, req1_ready,
    input  rf_load, rf_addr, rf_data,
    input  haz_a, haz_b
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  rd_addr_a, rd_addr_b,
    output req0_ready, req1_ready,
    output rf_load, rf_addr, rf_data,
    output haz_a, haz_b
  );
endinterface

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin on a last-grant pointer or fixed priority
// (requester 0 highest). Grants are suppressed while reset is asserted.
module rr_arb2
  import regfile_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid0,
  input  logic i_valid1,
  output logic o_gnt0,
  output logic o_gnt1
);

  logic r_last_gnt;
  logic w_gnt0;
  logic w_gnt1;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!i_rst) begin
      if (ARB_MODE == ARB_FIXED) begin
        w_gnt0 = i_valid0;
        w_gnt1 = i_valid1 & ~i_valid0;
      end else if (i_valid0 && i_valid1) begin
        // Contest: the requester that did not win last time goes next.
        w_gnt0 = r_last_gnt;
        w_gnt1 = ~r_last_gnt;
      end else begin
        w_gnt0 = i_valid0;
        w_gnt1 = i_valid1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_gnt <= 1'b1;
    end else if (w_gnt0) begin
      r_last_gnt <= 1'b0;
    end else if (w_gnt1) begin
      r_last_gnt <= 1'b1;
    end
  end

  assign o_gnt0 = w_gnt0;
  assign o_gnt1 = w_gnt1;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: grants one writeback per cycle, registers
// the write command, flags read hazards. Option: RFARB_R0_HARDWIRE_EN (r0 writes dropped).
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wr_arbiter_if.slave  bus
);

  wr_req_t           w_req0;
  wr_req_t           w_req1;
  wr_req_t           w_gnt_req;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_wr_en;
  logic              r_load;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  assign w_req0 = {bus.req0_valid, bus.req0_addr, bus.req0_data};
  assign w_req1 = {bus.req1_valid, bus.req1_addr, bus.req1_data};

  rr_arb2 #(.ARB_MODE(ARB_MODE)) u_arb (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid0 (bus.req0_valid),
    .i_valid1 (bus.req1_valid),
    .o_gnt0   (w_gnt0),
    .o_gnt1   (w_gnt1)
  );

  always_comb begin
    w_gnt_req = '0;
    if (w_gnt1) begin
      w_gnt_req = w_req1;
    end else if (w_gnt0) begin
      w_gnt_req = w_req0;
    end
  end

`ifdef RFARB_R0_HARDWIRE_EN
  // r0 reads as constant zero, so its writes handshake but never reach the file.
  assign w_wr_en = w_gnt_req.valid && (w_gnt_req.addr != '0);
`else
  assign w_wr_en = w_gnt_req.valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_load <= w_wr_en;
      if (w_wr_en) begin
        r_addr <= w_gnt_req.addr;
        r_data <= w_gnt_req.data;
      end
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.rf_load    = r_load;
  assign bus.rf_addr    = r_addr;
  assign bus.rf_data    = r_data;

  // In flight = accepted this cycle or being loaded into the file now.
  assign bus.haz_a = (r_load && (r_addr == bus.rd_addr_a)) ||
                     (w_wr_en && (w_gnt_req.addr == bus.rd_addr_a));
  assign bus.haz_b = (r_load && (r_addr == bus.rd_addr_b)) ||
                     (w_wr_en && (w_gnt_req.addr == bus.rd_addr_b));

endmodule
